// File: rtl/vproc_mem_model.sv
// Purpose: behavioural system memory behind the vproc unified memory port, with range checking and program-end detection.
// Latency: every request gets exactly one response, MEM_LATENCY cycles after it is sampled; stages shift every cycle.
// Backpressure: none; every request is accepted and the response pipeline never stalls.
module vproc_mem_model #(
    parameter int unsigned MEM_W       = 32,
    parameter int unsigned MEM_SZ      = 262144,
    parameter int unsigned MEM_LATENCY = 1,
    parameter logic [31:0] END_ADDR    = 32'h0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 mem_req_i,
    input  logic [31:0]          mem_addr_i,
    input  logic                 mem_we_i,
    input  logic [MEM_W/8-1:0]   mem_be_i,
    input  logic [MEM_W-1:0]     mem_wdata_i,
    output logic                 mem_rvalid_o,
    output logic                 mem_err_o,
    output logic [MEM_W-1:0]     mem_rdata_o,
    output logic                 prog_end_o,
    output logic [31:0]          req_cnt_o
);

    localparam int unsigned BW    = MEM_W / 8;
    localparam int unsigned OFF   = $clog2(BW);
    localparam int unsigned AW    = $clog2(MEM_SZ);
    localparam int unsigned DEPTH = MEM_SZ / BW;
    localparam int unsigned IW    = AW - OFF;

    // Not reset, so preloaded program and data survive between test programs.
    logic [MEM_W-1:0] mem_q [DEPTH];

    logic [IW-1:0]    word_idx;
    logic             addr_err;
    logic [MEM_W-1:0] rd_word;
    logic             end_hit;
    logic             unused_addr_bits;

    logic [MEM_LATENCY-1:0] pipe_vld;
    logic [MEM_LATENCY-1:0] pipe_err;
    logic [MEM_W-1:0]       pipe_dat [MEM_LATENCY];

    assign word_idx         = mem_addr_i[AW-1:OFF];
    assign addr_err         = |mem_addr_i[31:AW];
    // Read is taken before the write lands on the same edge: writes return the old word.
    assign rd_word          = addr_err ? '0 : mem_q[word_idx];
    assign end_hit          = mem_req_i && !mem_we_i && (mem_addr_i[31:OFF] == END_ADDR[31:OFF]);
    assign unused_addr_bits = ^mem_addr_i[OFF-1:0];

    assign mem_rvalid_o = pipe_vld[MEM_LATENCY-1];
    assign mem_err_o    = pipe_err[MEM_LATENCY-1];
    assign mem_rdata_o  = pipe_dat[MEM_LATENCY-1];

    // Byte-masked write of in-range requests; out-of-range writes change nothing.
    always_ff @(posedge clk_i) begin
        if (mem_req_i && mem_we_i && !addr_err) begin
            for (int b = 0; b < int'(BW); b++) begin
                if (mem_be_i[b]) begin
                    mem_q[word_idx][b*8 +: 8] <= mem_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 captures the request, all stages shift every cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld <= '0;
            pipe_err <= '0;
            for (int i = 0; i < int'(MEM_LATENCY); i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= mem_req_i;
            pipe_err[0] <= mem_req_i & addr_err;
            pipe_dat[0] <= mem_req_i ? rd_word : '0;
            for (int i = 1; i < int'(MEM_LATENCY); i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_err[i] <= pipe_err[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    // Request counter and sticky program-end flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_cnt_o  <= '0;
            prog_end_o <= 1'b0;
        end else begin
            if (mem_req_i) begin
                req_cnt_o <= req_cnt_o + 32'd1;
            end
            if (end_hit) begin
                prog_end_o <= 1'b1;
            end
        end
    end

    // An unknown request strobe makes every downstream response meaningless.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(mem_req_i));

endmodule
